multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Sequencing controller for the multi-cycle RV32I core.
// - Drives the shared memory port, the instruction register, PC update, register write-back and datapath muxes.
// - Decision inputs: opcode/funct3 from instruction_decoder and branch_taken from the ALU.
// - Runs one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
// - Traps (sticky) on illegal opcodes or memory timeout.
// PARAMETERS
// - MEM_TIMEOUT  default 16  max cycles mem_req_o may wait for mem_ready_i; 0 disables the watchdog.
// PORTS
// - clk_i             input   1  core clock, all state on rising edge
// - rst_ni            input   1  asynchronous active-low reset
// - run_i             input   1  1 = fetch allowed; sampled only in FETCH before a request starts
// - opcode_i          input   7  opcode_o of instruction_decoder (decodes the IR)
// - funct3_i          input   3  funct3_o of instruction_decoder
// - branch_taken_i    input   1  ALU compare result, valid in EXEC
// - mem_ready_i       input   1  memory accepted/completed the current request
// - mem_req_o         output  1  memory request, held until mem_ready_i
// - mem_we_o          output  1  1 = store; valid while mem_req_o
// - mem_is_fetch_o    output  1  1 = address from PC, 0 = address from ALU result
// - ir_write_o        output  1  latch instruction word into IR
// - pc_write_o        output  1  update PC this cycle
// - pc_sel_o          output  2  0 = PC+4, 1 = PC_old+imm (branch/JAL), 2 = ALU result & ~1 (JALR)
// - reg_write_o       output  1  write rd
// - wb_sel_o          output  2  0 = ALU, 1 = memory data, 2 = PC_old+4, 3 = reserved
// - alu_a_pc_o        output  1  ALU A operand = PC_old (AUIPC); else rs1 (LUI: datapath forces 0)
// - alu_b_imm_o       output  1  ALU B operand = immediate; else rs2
// - retire_o          output  1  one-cycle pulse when an instruction completes
// - state_o           output  3  current state encoding
// - trap_cause_o      output  2  0 none, 1 illegal opcode, 2 memory timeout
// BEHAVIOUR
// - State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
// - Reset (async, rst_ni=0):
//   - state=FETCH and all outputs 0 immediately, including mem_req_o mid-transaction.
//   - Watchdog counter=0; trap cleared.
// - FETCH:
//   - run_i=0 and no request pending: idle, mem_req_o=0.
//   - Otherwise: mem_req_o=1, mem_is_fetch_o=1. Once asserted, the request holds regardless of run_i.
//   - On mem_ready_i in the same cycle: ir_write_o=1, pc_write_o=1, pc_sel_o=0, next state DECODE.
// - DECODE: one cycle, no side effects. Legal opcodes go to EXEC:
//   - 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17.
//   - Any other opcode, or funct3 in {2,3} for 0x63: TRAP, trap_cause_o=1.
// - EXEC:
//   - ALU source selects are driven per opcode.
//   - BRANCH (0x63): pc_write_o=branch_taken_i, pc_sel_o=1, retire_o=1, next FETCH.
//   - JAL (0x6F): pc_write_o=1, pc_sel_o=1. JALR (0x67): pc_write_o=1, pc_sel_o=2. Both next WB.
//   - LOAD/STORE: next MEM. All others: next WB.
// - MEM:
//   - mem_req_o=1, mem_is_fetch_o=0, mem_we_o=1 for STORE.
//   - On mem_ready_i: STORE sets retire_o=1 and goes to FETCH; LOAD goes to WB.
// - WB:
//   - reg_write_o=1 and retire_o=1, next FETCH.
//   - wb_sel_o: LOAD=1, JAL/JALR=2, others 0.
// - Latency with zero-wait memory (ready in the request's first cycle):
//   - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
//   - BRANCH: 3 cycles. STORE: 4 cycles. LOAD: 5 cycles.
// - Watchdog:
//   - Counter increments each cycle mem_req_o=1 and mem_ready_i=0; clears when the request completes.
//   - Reaching MEM_TIMEOUT: drop the request, go to TRAP, trap_cause_o=2.
// - TRAP:
//   - All strobes 0; state and trap_cause_o held until reset.
//   - mem_ready_i is ignored in TRAP and whenever mem_req_o=0.
// - Trap precedence: an illegal opcode is reported even if a timeout was pending; only one cause is ever latched.
// - retire_o never asserts in the same cycle as a trap entry.
// TESTING
// - Reset, run_i=1, ready=1 each request, IR=0x002081B3 (ADD):
//   - States 0,1,2,4,0; reg_write_o and retire_o=1 in the WB cycle; wb_sel_o=0.
// - IR=0x00A52283 (LW), ready 2 cycles late in MEM:
//   - Stays in MEM 3 cycles with mem_we_o=0, then WB with wb_sel_o=1; 7 cycles total.
// - IR=0x0020A223 (SW):
//   - MEM with mem_we_o=1; retire_o=1 on the ready cycle; reg_write_o never asserts.
// - BEQ (0x00208463):
//   - branch_taken_i=1 gives pc_write_o=1, pc_sel_o=1 in EXEC, 3 cycles.
//   - branch_taken_i=0 gives pc_write_o=0.
// - IR=0xFFFFFFFF:
//   - TRAP after DECODE, trap_cause_o=1, state_o=7 held 20 cycles; rst_ni low returns state_o=0.
// - MEM_TIMEOUT=4, mem_ready_i stuck 0 in FETCH:
//   - mem_req_o high 4 cycles, then TRAP, trap_cause_o=2.
// - Async reset asserted mid-MEM: mem_req_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Shared memory-port handshake between the multi-cycle controller and the memory.
// The controller owns the request side; memory answers with a ready strobe.
interface multicycle_control_fsm_if;
    logic mem_req_o;
    logic mem_we_o;
    logic mem_is_fetch_o;
    logic mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_is_fetch_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_is_fetch_o,
        output mem_ready_i
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB
// with a sticky TRAP state for illegal opcodes and memory-request timeouts.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    multicycle_control_fsm_if.master       mem,
    input  logic                           run_i,
    input  logic [6:0]                     opcode_i,
    input  logic [2:0]                     funct3_i,
    input  logic                           branch_taken_i,
    output logic                           ir_write_o,
    output logic                           pc_write_o,
    output logic [1:0]                     pc_sel_o,
    output logic                           reg_write_o,
    output logic [1:0]                     wb_sel_o,
    output logic                           alu_a_pc_o,
    output logic                           alu_b_imm_o,
    output logic                           retire_o,
    output logic [2:0]                     state_o,
    output logic [1:0]                     trap_cause_o
);

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    localparam int unsigned CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t          state, state_n;
    logic [1:0]      cause, cause_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pend, pend_n;
    logic            req, waiting, timeout, legal;

    // Request is gated by rst_ni so it drops the instant reset asserts.
    assign req     = ((state == S_FETCH) && rst_ni && (run_i || pend)) || (state == S_MEM);
    assign waiting = req && !mem.mem_ready_i;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt == LIMIT);

    always_comb begin
        unique case (opcode_i)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_BR:   legal = (funct3_i != 3'd2) && (funct3_i != 3'd3);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_FETCH;
            cause <= 2'd0;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cause <= cause_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n        = state;
        cause_n        = cause;
        pend_n         = 1'b0;
        cnt_n          = (waiting && !timeout) ? cnt + 1'b1 : '0;
        mem.mem_req_o      = req;
        mem.mem_we_o       = 1'b0;
        mem.mem_is_fetch_o = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_sel_o       = 2'd0;
        reg_write_o    = 1'b0;
        wb_sel_o       = 2'd0;
        alu_a_pc_o     = 1'b0;
        alu_b_imm_o    = 1'b0;
        retire_o       = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem.mem_is_fetch_o = req;
                if (req) begin
                    if (mem.mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_n    = S_DECODE;
                    end else if (timeout) begin
                        state_n = S_TRAP;
                        cause_n = 2'd2;
                    end else begin
                        pend_n = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_n = S_EXEC;
                end else begin
                    state_n = S_TRAP;
                    cause_n = 2'd1;
                end
            end
            S_EXEC: begin
                alu_a_pc_o  = (opcode_i == OP_AUIPC);
                alu_b_imm_o = (opcode_i == OP_I) || (opcode_i == OP_LOAD) || (opcode_i == OP_STORE) ||
                              (opcode_i == OP_JALR) || (opcode_i == OP_LUI) || (opcode_i == OP_AUIPC);
                state_n     = S_WB;
                unique case (opcode_i)
                    OP_BR: begin
                        pc_write_o = branch_taken_i;
                        pc_sel_o   = 2'd1;
                        retire_o   = 1'b1;
                        state_n    = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write_o = 1'b1;
                        pc_sel_o   = 2'd1;
                    end
                    OP_JALR: begin
                        pc_write_o = 1'b1;
                        pc_sel_o   = 2'd2;
                    end
                    OP_LOAD, OP_STORE: state_n = S_MEM;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem.mem_we_o = (opcode_i == OP_STORE);
                if (mem.mem_ready_i) begin
                    if (opcode_i == OP_STORE) begin
                        retire_o = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timeout) begin
                    state_n = S_TRAP;
                    cause_n = 2'd2;
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                if (opcode_i == OP_LOAD)
                    wb_sel_o = 2'd1;
                else if ((opcode_i == OP_JAL) || (opcode_i == OP_JALR))
                    wb_sel_o = 2'd2;
                state_n = S_FETCH;
            end
            S_TRAP: ;
            default: state_n = S_FETCH;
        endcase
    end

    assign state_o      = state;
    assign trap_cause_o = cause;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised bench: each instruction is expanded into an expected per-cycle trace
// from the controller's phase rules, then replayed against the DUT.
module tb_multicycle_control_fsm;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       ir_write, pc_write, reg_write, alu_a_pc, alu_b_imm, retire;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_control_fsm_if mif();

    multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mem            (mif),
        .run_i          (run),
        .opcode_i       (opcode),
        .funct3_i       (funct3),
        .branch_taken_i (branch_taken),
        .ir_write_o     (ir_write),
        .pc_write_o     (pc_write),
        .pc_sel_o       (pc_sel),
        .reg_write_o    (reg_write),
        .wb_sel_o       (wb_sel),
        .alu_a_pc_o     (alu_a_pc),
        .alu_b_imm_o    (alu_b_imm),
        .retire_o       (retire),
        .state_o        (state),
        .trap_cause_o   (trap_cause)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, isf, irw, pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] wbs;
        logic       apc, bimm, ret;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        logic       run, ready, bt;
        logic [6:0] op;
        logic [2:0] f3;
        out_t       exp;
    } cyc_t;

    out_t obs;
    assign obs = {state, mif.mem_req_o, mif.mem_we_o, mif.mem_is_fetch_o, ir_write, pc_write,
                  pc_sel, reg_write, wb_sel, alu_a_pc, alu_b_imm, retire, trap_cause};

    cyc_t trace[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
        foreach (legal_ops[i])
            if (legal_ops[i] == op) return (op != 7'h63) || (f3 != 3'd2 && f3 != 3'd3);
        return 1'b0;
    endfunction

    // {alu_a_pc, alu_b_imm}: only AUIPC takes PC as A; R-type and branches use rs2.
    function automatic logic [1:0] alu_sel(input logic [6:0] op);
        case (op)
            7'h17:                               return 2'b11;
            7'h13, 7'h03, 7'h23, 7'h67, 7'h37:   return 2'b01;
            default:                             return 2'b00;
        endcase
    endfunction

    task automatic push(input out_t o, input logic r, input logic rdy, input logic [6:0] op,
                        input logic [2:0] f3, input logic bt);
        cyc_t c;
        c.run = r; c.ready = rdy; c.op = op; c.f3 = f3; c.bt = bt; c.exp = o;
        trace.push_back(c);
    endtask

    task automatic add_trap(input logic [1:0] c, input int unsigned n);
        out_t o;
        for (int unsigned i = 0; i < n; i++) begin
            o = '0; o.st = 3'd7; o.cause = c;
            push(o, rb(), rb(), 7'($urandom), 3'($urandom), rb());
        end
    endtask

    // fw/mw = wait cycles before ready; a value of TO means ready never comes.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                         input int unsigned fw, input int unsigned mw, input int unsigned idle,
                         input int unsigned trap_n, output bit trapped);
        out_t o;
        trapped = 1'b0;
        trace.delete();
        for (int unsigned i = 0; i < idle; i++) begin
            o = '0;
            push(o, 1'b0, rb(), 7'($urandom), 3'($urandom), rb());
        end
        for (int unsigned i = 0; i < fw; i++) begin
            o = '0; o.req = 1'b1; o.isf = 1'b1;
            push(o, (i == 0) ? 1'b1 : rb(), 1'b0, 7'($urandom), 3'($urandom), rb());
        end
        if (fw >= TO) begin
            add_trap(2'd2, trap_n); trapped = 1'b1; return;
        end
        o = '0; o.req = 1'b1; o.isf = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        push(o, (fw == 0) ? 1'b1 : rb(), 1'b1, 7'($urandom), 3'($urandom), rb());
        o = '0; o.st = 3'd1;
        push(o, rb(), rb(), op, f3, rb());
        if (!is_legal(op, f3)) begin
            add_trap(2'd1, trap_n); trapped = 1'b1; return;
        end
        o = '0; o.st = 3'd2; {o.apc, o.bimm} = alu_sel(op);
        case (op)
            7'h63: begin
                o.pcw = bt; o.pcs = 2'd1; o.ret = 1'b1;
                push(o, rb(), rb(), op, f3, bt);
                return;
            end
            7'h6F: begin o.pcw = 1'b1; o.pcs = 2'd1; end
            7'h67: begin o.pcw = 1'b1; o.pcs = 2'd2; end
            default: ;
        endcase
        push(o, rb(), rb(), op, f3, bt);
        if (op == 7'h03 || op == 7'h23) begin
            for (int unsigned i = 0; i < mw; i++) begin
                o = '0; o.st = 3'd3; o.req = 1'b1; o.we = (op == 7'h23);
                push(o, rb(), 1'b0, op, f3, rb());
            end
            if (mw >= TO) begin
                add_trap(2'd2, trap_n); trapped = 1'b1; return;
            end
            o = '0; o.st = 3'd3; o.req = 1'b1; o.we = (op == 7'h23); o.ret = (op == 7'h23);
            push(o, rb(), 1'b1, op, f3, rb());
            if (op == 7'h23) return;
        end
        o = '0; o.st = 3'd4; o.rw = 1'b1; o.ret = 1'b1;
        o.wbs = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
        push(o, rb(), rb(), op, f3, rb());
    endtask

    task automatic play(input string tag, input int limit);
        int n;
        n = (limit < 0) ? trace.size() : limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run = trace[i].run; mif.mem_ready_i = trace[i].ready;
            opcode = trace[i].op; funct3 = trace[i].f3; branch_taken = trace[i].bt;
            #2;
            check_eq($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(trace[i].exp));
        end
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        run   = 1'b1;
        #1;
        check_eq(tag, 32'(obs), 32'd0);
        repeat (2) @(negedge clk);
        check_eq({tag, "_held"}, 32'(obs), 32'd0);
        run = 1'b0; mif.mem_ready_i = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        bit tr;
        logic [6:0] op;
        logic [2:0] f3;
        int unsigned fw, mw;
        rst_n = 1'b0; run = 1'b0; opcode = '0; funct3 = '0; branch_taken = 1'b0;
        mif.mem_ready_i = 1'b0;
        apply_reset("reset");

        build(7'h33, 3'd0, 1'b0, 0, 0, 0, 0, tr); play("add", -1);
        build(7'h03, 3'd2, 1'b0, 0, 2, 0, 0, tr); play("lw", -1);
        build(7'h23, 3'd2, 1'b0, 0, 0, 0, 0, tr); play("sw", -1);
        build(7'h63, 3'd0, 1'b1, 0, 0, 0, 0, tr); play("beq_t", -1);
        build(7'h63, 3'd0, 1'b0, 0, 0, 0, 0, tr); play("beq_nt", -1);
        build(7'h6F, 3'd0, 1'b0, 1, 0, 2, 0, tr); play("jal", -1);
        build(7'h67, 3'd0, 1'b0, 0, 0, 0, 0, tr); play("jalr", -1);
        build(7'h17, 3'd0, 1'b0, 0, 0, 0, 0, tr); play("auipc", -1);

        build(7'h7F, 3'd7, 1'b0, 0, 0, 0, 20, tr); play("illegal", -1);
        apply_reset("reset_after_illegal");
        build(7'h63, 3'd3, 1'b0, 0, 0, 0, 3, tr); play("bad_branch", -1);
        apply_reset("reset_after_bad_branch");

        build(7'h33, 3'd0, 1'b0, TO, 0, 0, 6, tr); play("fetch_timeout", -1);
        apply_reset("reset_after_fetch_to");
        build(7'h03, 3'd0, 1'b0, TO - 1, TO, 0, 6, tr); play("mem_timeout", -1);
        apply_reset("reset_after_mem_to");

        // Stop partway through MEM with the request live, then yank reset mid-cycle.
        build(7'h03, 3'd2, 1'b0, 0, 3, 0, 0, tr); play("lw_cut", 4);
        #1;
        apply_reset("async_reset_mid_mem");

        for (int k = 0; k < 80; k++) begin
            op = legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd0;
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                if (op == 7'h63) f3 = 3'd2;
            end
            fw = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            mw = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            build(op, f3, rb(), fw, mw, $urandom_range(0, 2), 3, tr);
            play($sformatf("rand%0d_op%h", k, op), -1);
            if (tr) apply_reset($sformatf("rand%0d_reset", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
